// File: rtl/lif_if.sv
// Handshake and data bundle between the LIF neuron scheduler and its host.
// The host sits on the master side; the scheduler sits on the slave side.
interface lif_if #(
  parameter int N_NEURONS = 8,
  parameter int W         = 6
);
  localparam int IW = $clog2(N_NEURONS);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        cur_idx;
  logic [W-1:0]         cur_data;
  logic                 cfg_we;
  logic [W-1:0]         cfg_thr;
  logic [N_NEURONS-1:0] spikes;
  logic [IW:0]          spike_count;

  modport master (
    output start, cur_data, cfg_we, cfg_thr,
    input  busy, done, cur_idx, spikes, spike_count
  );

  modport slave (
    input  start, cur_data, cfg_we, cfg_thr,
    output busy, done, cur_idx, spikes, spike_count
  );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed leaky integrate-and-fire neurons, one neuron per cycle per tick.
// Optional refractory period is enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_scheduler #(
  parameter int N_NEURONS    = 8,
  parameter int W            = 6,
  parameter int REFRAC_TICKS = 2
) (
  input logic  clk,
  input logic  rst_n,
  lif_if.slave bus
);
  localparam int IW = $clog2(N_NEURONS);
  localparam logic [W-1:0] THR_RST = W'(1) << (W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  if (N_NEURONS < 2 || N_NEURONS > 16 || REFRAC_TICKS < 0) begin : g_param_check
    $error("lif_neuron_scheduler: unsupported parameter set");
  end

  logic [1:0]           fsm;
  logic [IW-1:0]        slot;
  logic [W-1:0]         thr_cfg;
  logic [W-1:0]         thr_active;
  logic [W-1:0]         state_q [N_NEURONS];
  logic [N_NEURONS-1:0] flag_q;
  logic [N_NEURONS-1:0] spikes_q;
  logic [IW:0]          count_q;

  logic [W-1:0] cur_s;
  logic         cur_f;
  logic [W-1:0] leak;
  logic [W:0]   sum;
  logic [W-1:0] sat_s;
  logic         raw_flag;
  logic [W-1:0] next_s;
  logic         next_f;
  logic [IW:0]  pop;

  // NOTE: combinational logic uses blocking '=' with a default for every output
  // first, so no path can infer a latch; clocked state always uses '<='.
  always_comb begin
    cur_s    = state_q[slot];
    cur_f    = flag_q[slot];
    leak     = cur_f ? '0 : (cur_s >> 1);
    sum      = {1'b0, bus.cur_data} + {1'b0, leak};
    sat_s    = sum[W] ? '1 : sum[W-1:0];
    raw_flag = (cur_s >= thr_active);
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURONS; i++) pop = pop + (IW+1)'(flag_q[i]);
  end

`ifdef LIF_REFRACTORY_EN
  localparam int RW = (REFRAC_TICKS < 1) ? 1 : $clog2(REFRAC_TICKS + 1);

  logic [RW-1:0] refrac_q [N_NEURONS];
  logic          in_refrac;

  always_comb begin
    in_refrac = (refrac_q[slot] != '0);
    next_s    = in_refrac ? '0 : sat_s;
    next_f    = in_refrac ? 1'b0 : raw_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
    end else if (fsm == SWEEP) begin
      if (in_refrac)     refrac_q[slot] <= refrac_q[slot] - RW'(1);
      else if (raw_flag) refrac_q[slot] <= RW'(REFRAC_TICKS);
    end
  end
`else
  always_comb begin
    next_s = sat_s;
    next_f = raw_flag;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      slot       <= '0;
      thr_cfg    <= THR_RST;
      thr_active <= THR_RST;
      flag_q     <= '0;
      spikes_q   <= '0;
      count_q    <= '0;
      // NOTE: the membrane array is cleared by reset because every neuron must
      // start a run from rest; a plain storage array would normally be left unreset.
      for (int i = 0; i < N_NEURONS; i++) state_q[i] <= '0;
    end else begin
      if (bus.cfg_we) thr_cfg <= bus.cfg_thr;

      case (fsm)
        IDLE: begin
          if (bus.start) begin
            fsm        <= SWEEP;
            slot       <= '0;
            // A write in the start cycle must already govern this sweep.
            thr_active <= bus.cfg_we ? bus.cfg_thr : thr_cfg;
          end
        end
        SWEEP: begin
          state_q[slot] <= next_s;
          flag_q[slot]  <= next_f;
          if (slot == IW'(N_NEURONS - 1)) begin
            fsm  <= DONE;
            slot <= '0;
          end else begin
            slot <= slot + IW'(1);
          end
        end
        DONE: begin
          spikes_q <= flag_q;
          count_q  <= pop;
          fsm      <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (fsm != IDLE);
  assign bus.done        = (fsm == DONE);
  assign bus.cur_idx     = (fsm == SWEEP) ? slot : '0;
  assign bus.spikes      = spikes_q;
  assign bus.spike_count = count_q;

endmodule

// File: doc/lif_neuron_scheduler.md
LIF_NEURON_SCHEDULER -- requirements
Module: lif_neuron_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, 8, number of time-multiplexed virtual neurons (power of two, 2..16).
REQ-002 SHALL have parameter W, 6, membrane state and current width.
REQ-003 SHALL have parameter REFRAC_TICKS, 2, refractory length in ticks (used only with REFRACTORY_EN).
REQ-004 SHALL have port clk input 1: single clock, rising edge.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start input 1: request one tick sweep over all neurons.
REQ-007 SHALL have port busy output 1: sweep in progress.
REQ-008 SHALL have port done output 1: one-cycle pulse at sweep completion.
REQ-009 SHALL have port cur_idx output log2(N_NEURONS): index of the neuron whose current is requested.
REQ-010 SHALL have port cur_data input W: current for neuron cur_idx, sampled the same cycle.
REQ-011 SHALL have port cfg_we input 1: threshold write strobe.
REQ-012 SHALL have port cfg_thr input W: threshold write data.
REQ-013 SHALL have port spikes output N_NEURONS: per-neuron spike flags of the last completed tick.
REQ-014 SHALL have port spike_count output log2(N_NEURONS)+1: number of set bits in spikes.

Function
REQ-015 SHALL implement FSM IDLE -> SWEEP -> DONE -> IDLE; IDLE->SWEEP on start, SWEEP->DONE after slot N_NEURONS-1, DONE->IDLE unconditionally.
REQ-016 SHALL process exactly one neuron per SWEEP cycle, index 0 first, incrementing by 1; sweep latency from start to done pulse = N_NEURONS+1 cycles.
REQ-017 SHALL drive busy=1 in SWEEP and DONE, 0 in IDLE; done=1 only in DONE.
REQ-018 SHALL ignore start while busy=1; start asserted in the DONE cycle is ignored, start in the following IDLE cycle is accepted.
REQ-019 SHALL drive cur_idx = slot index in SWEEP and 0 otherwise.
REQ-020 SHALL, for slot i with stored state s and stored flag f, compute next state = cur_data + (f ? 0 : s>>1), saturating at 2^W-1 (no wrap).
REQ-021 SHALL compute new flag for slot i as (s >= thr_active), using the pre-update s.
REQ-022 SHALL write back next state and new flag for neuron i at the end of slot i; neurons not yet visited keep previous-tick values.
REQ-023 SHALL update spikes and spike_count together in the DONE cycle with all N new flags; both hold stable between DONE cycles.
REQ-024 SHALL hold cfg threshold register thr_cfg, written on cfg_we in any state.
REQ-025 SHALL copy thr_cfg to thr_active on IDLE->SWEEP; a cfg write during a sweep takes effect from the next sweep only.
REQ-026 SHALL, on cfg_we and start in the same IDLE cycle, use the newly written value for that sweep.
REQ-027 SHALL treat thr_active=0 as every neuron spiking every tick.

Reset
REQ-028 SHALL on rst_n=0, asynchronously: FSM=IDLE, busy=0, done=0, cur_idx=0, all states=0, all flags=0, spikes=0, spike_count=0, thr_cfg=thr_active=32 (2^(W-1)).
REQ-029 SHALL on reset mid-sweep abandon the sweep with no done pulse and no partial spikes update.

Configuration
REQ-030 SHALL, with macro LIF_REFRACTORY_EN defined, keep a per-neuron counter loaded with REFRAC_TICKS when a new flag is 1; while counter>0, the neuron's next state is forced 0, new flag is 0, and the counter decrements once per visit; reset clears counters.
REQ-031 SHALL, without LIF_REFRACTORY_EN, contain no refractory counters and behave per REQ-020..REQ-022 only.

Verification
REQ-032 SHALL cover: reset, thr=32, start, cur_data=10 all neurons -> done at cycle 9, spikes=0, states=10; second tick states=15, spikes=0.
REQ-033 SHALL cover: cur_data=40 neuron 3 only, two ticks -> tick 2 spikes=8'h08, spike_count=1; tick 3 neuron 3 state=40 (leak term dropped).
REQ-034 SHALL cover: cur_data=63 with stored state 40 -> next state 63 (saturated, not 19).
REQ-035 SHALL cover: cfg_we thr=5 mid-sweep -> current sweep uses 32, next sweep uses 5; start during busy ignored, no extra done.
REQ-036 SHALL cover: rst_n low at slot 4 -> busy=0 immediately, spikes stays 0, no done pulse.
REQ-037 SHALL cover (LIF_REFRACTORY_EN): neuron spikes in tick k -> state 0, flag 0 for ticks k+1 and k+2, normal integration from tick k+3.
